// File: rtl/archie_ldr_pkg.sv
// Shared definitions for the Archimedes RAM loader paths (download mux and upload reader).
package archie_ldr_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} upl_state_t;

  localparam logic        HALF_LO        = 1'b0;
  localparam logic        HALF_HI        = 1'b1;
  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
  localparam logic [25:0] DEF_BASE_ADDR  = 26'h400000;

  function automatic logic [15:0] sel_half(input logic [31:0] dat, input logic half);
    return (half == HALF_HI) ? dat[31:16] : dat[15:0];
  endfunction

endpackage

// File: rtl/wb_ram_uploader.sv
// Streams an SDRAM region back to the HPS over ioctl upload, 16 bits per ioctl_rd,
// through a wishbone classic read initiator with a one-word cache.
module wb_ram_uploader
  import archie_ldr_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd1,
  parameter logic [7:0]  TIMEOUT      = 8'd255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        bus_req,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [25:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        rd_error
);

  upl_state_t  state_q, state_d;
  logic        stb_q, stb_d;
  logic [25:0] adr_q, adr_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [15:0] din_q, din_d;
  logic        err_q, err_d;
  logic        valid_q, valid_d;
  logic [21:0] tag_q, tag_d;
  logic        half_q, half_d;
  logic [31:0] data_q, data_d;
  logic        active, active_q, act_rise, hit;
  logic        unused_addr_bits;

  // Bit 0 is always zero and bit 24 lies outside the mapped window.
  assign unused_addr_bits = ^{ioctl_addr[24], ioctl_addr[0]};

  assign active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign act_rise = active && !active_q;
  // A read landing on the upload start edge must miss: invalidation wins.
  assign hit      = valid_q && (tag_q == ioctl_addr[23:2]) && !act_rise;
  assign cnt_inc  = cnt_q + 8'd1;

  assign bus_req    = active;
  assign ioctl_wait = (state_q != IDLE) || (ioctl_rd && !hit && active);
  assign ioctl_din  = din_q;
  assign rd_error   = err_q;
  assign wb_cyc     = stb_q;
  assign wb_stb     = stb_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_cti     = WB_CTI_CLASSIC;
  assign wb_adr     = adr_q;

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    err_d   = err_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    half_d  = half_q;
    data_d  = data_q;
    if (act_rise) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (active && ioctl_rd) begin
          if (hit) begin
            din_d = sel_half(data_q, ioctl_addr[1]);
          end else begin
            tag_d   = ioctl_addr[23:2];
            half_d  = ioctl_addr[1];
            adr_d   = BASE_ADDR + {2'b00, ioctl_addr[23:2], 2'b00};
            stb_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!active) begin
          stb_d   = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (wb_ack) begin
          stb_d   = 1'b0;
          data_d  = wb_dat_i;
          valid_d = 1'b1;
          din_d   = sel_half(wb_dat_i, half_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            stb_d   = 1'b0;
            din_d   = 16'hFFFF;
            err_d   = 1'b1;
            valid_d = 1'b0;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      stb_q    <= 1'b0;
      adr_q    <= '0;
      cnt_q    <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      tag_q    <= '0;
      half_q   <= HALF_LO;
      data_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stb_q    <= stb_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      half_q   <= half_d;
      data_q   <= data_d;
      active_q <= active;
    end
  end

endmodule

// File: tb/tb_wb_ram_uploader.sv
// Directed bench for wb_ram_uploader with a small SDRAM wishbone responder model.
module tb_wb_ram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;
  logic        bus_req;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [25:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        rd_error;

  logic        auto_en, auto_ack_q, man_ack, stb_prev;
  int          cyc_cnt, stb_hi;
  logic [25:0] last_adr;
  int          n_vec, n_err;
  int          wc, c0, h0;

  always #5 clk_sys = ~clk_sys;

  wb_ram_uploader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .bus_req(bus_req),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_cti(wb_cti), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .rd_error(rd_error)
  );

  // RAM contents: two known words, everything else returns its own address.
  always_comb begin
    case (wb_adr)
      26'h400000: wb_dat_i = 32'hDEADBEEF;
      26'h400004: wb_dat_i = 32'h12345678;
      default:    wb_dat_i = {6'd0, wb_adr};
    endcase
  end

  assign wb_ack = auto_ack_q | man_ack;

  // Responder acks one cycle after it sees stb; also counts bus cycles.
  always @(posedge clk_sys) begin
    auto_ack_q <= auto_en && wb_stb && !auto_ack_q;
    stb_prev   <= wb_stb;
    if (wb_stb) stb_hi <= stb_hi + 1;
    if (wb_stb && !stb_prev) begin
      cyc_cnt  <= cyc_cnt + 1;
      last_adr <= wb_adr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  // Issue one read; wcnt = cycles ioctl_wait was high, starting with the strobe cycle.
  task automatic do_rd(input logic [24:0] a, output int wcnt);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    #1;
    wcnt = ioctl_wait ? 1 : 0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    while (ioctl_wait && wcnt < 400) begin
      wcnt++;
      tick();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    cyc_cnt = 0; stb_hi = 0; last_adr = '0;
    auto_en = 1'b1; auto_ack_q = 1'b0; man_ack = 1'b0; stb_prev = 1'b0;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd1;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(); tick();
    chk("rst_din", 32'(ioctl_din), 32'h0);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_stb", 32'(wb_stb), 32'h0);
    chk("rst_adr", 32'(wb_adr), 32'h0);
    chk("rst_err", 32'(rd_error), 32'h0);
    chk("consts", {23'd0, wb_we, wb_sel, wb_cti, wb_cyc}, {23'd0, 1'b0, 4'hF, 3'b000, 1'b0});
    reset = 1'b0;
    tick();

    // 1: miss then hit on the same word
    ioctl_upload = 1'b1;
    tick();
    chk("t1_busreq", 32'(bus_req), 32'h1);
    c0 = cyc_cnt;
    do_rd(25'h0, wc);
    chk("t1_miss_wait", wc, 4);
    chk("t1_miss_din", 32'(ioctl_din), 32'hBEEF);
    chk("t1_adr", 32'(last_adr), 32'h400000);
    do_rd(25'h2, wc);
    chk("t1_hit_wait", wc, 0);
    chk("t1_hit_din", 32'(ioctl_din), 32'hDEAD);
    chk("t1_cycles", cyc_cnt - c0, 1);

    // 2: fresh upload, sequential halfwords
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    c0 = cyc_cnt;
    do_rd(25'h0, wc);
    chk("t2_d0", 32'(ioctl_din), 32'hBEEF);
    do_rd(25'h2, wc);
    chk("t2_d2", 32'(ioctl_din), 32'hDEAD);
    do_rd(25'h4, wc);
    chk("t2_d4", 32'(ioctl_din), 32'h5678);
    chk("t2_adr4", 32'(last_adr), 32'h400004);
    do_rd(25'h6, wc);
    chk("t2_d6", 32'(ioctl_din), 32'h1234);
    chk("t2_cycles", cyc_cnt - c0, 2);
    // bit 24 ignored: aliases the cached word
    do_rd(25'h1000006, wc);
    chk("t2_a24_wait", wc, 0);
    chk("t2_a24_din", 32'(ioctl_din), 32'h1234);
    chk("t2_a24_cycles", cyc_cnt - c0, 2);

    // 3: no ack -> timeout
    auto_en = 1'b0;
    h0 = stb_hi;
    do_rd(25'h8, wc);
    chk("t3_wait", wc, 257);
    chk("t3_stb_hi", stb_hi - h0, 255);
    chk("t3_stb", 32'(wb_stb), 32'h0);
    chk("t3_din", 32'(ioctl_din), 32'hFFFF);
    chk("t3_err", 32'(rd_error), 32'h1);
    ioctl_upload = 1'b0;
    tick();
    chk("t3_err_sticky", 32'(rd_error), 32'h1);
    ioctl_upload = 1'b1;
    tick();
    chk("t3_err_clr", 32'(rd_error), 32'h0);
    auto_en = 1'b1;

    // 4: other index is not served
    ioctl_index = 8'd3;
    tick();
    chk("t4_busreq", 32'(bus_req), 32'h0);
    c0 = cyc_cnt;
    ioctl_addr = 25'h4; ioctl_rd = 1'b1;
    #1;
    chk("t4_wait", 32'(ioctl_wait), 32'h0);
    tick();
    ioctl_rd = 1'b0;
    tick();
    chk("t4_stb", 32'(wb_stb), 32'h0);
    chk("t4_din", 32'(ioctl_din), 32'hFFFF);
    chk("t4_cycles", cyc_cnt - c0, 0);

    // 5: upload dropped mid-fetch, late ack ignored
    ioctl_index = 8'd1;
    auto_en = 1'b0;
    tick();
    ioctl_addr = 25'h0; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("t5_stb_up", 32'(wb_stb), 32'h1);
    tick(); tick();
    ioctl_upload = 1'b0;
    #1;
    chk("t5_stb_hold", 32'(wb_stb), 32'h1);
    tick();
    chk("t5_stb_drop", 32'(wb_stb), 32'h0);
    chk("t5_wait", 32'(ioctl_wait), 32'h0);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    tick();
    chk("t5_din", 32'(ioctl_din), 32'hFFFF);
    chk("t5_stb_idle", 32'(wb_stb), 32'h0);
    ioctl_upload = 1'b1;
    auto_en = 1'b1;
    tick();
    c0 = cyc_cnt;
    do_rd(25'h2, wc);
    chk("t5_refetch_wait", wc, 4);
    chk("t5_refetch_din", 32'(ioctl_din), 32'hDEAD);
    chk("t5_refetch_cyc", cyc_cnt - c0, 1);

    // 6: reset during fetch
    auto_en = 1'b0;
    ioctl_addr = 25'h4; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    chk("t6_stb_up", 32'(wb_stb), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("t6_stb", 32'(wb_stb), 32'h0);
    chk("t6_wait", 32'(ioctl_wait), 32'h0);
    chk("t6_din", 32'(ioctl_din), 32'h0);
    reset = 1'b0;
    auto_en = 1'b1;
    tick();
    do_rd(25'h6, wc);
    chk("t6_after_wait", wc, 4);
    chk("t6_after_din", 32'(ioctl_din), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
